decay_time_histogram: RTL and testbench
=======================================

DECAY_TIME_HISTOGRAM -- requirements
Module: decay_time_histogram

Interface
REQ-001 Single clock; reset is asynchronous and active-high; the block SHALL have the following ports:
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 double_trig  input  1  level from the upstream double-pulse stage; high while a decay candidate is flagged.
REQ-005 delta_time  input  16  decay interval in clk cycles; valid when double_trig is high.
REQ-006 enable  input  1  1 = accept events; 0 = ignore edges, no counters change.
REQ-007 clear  input  1  single-cycle pulse; starts histogram and counter clear.
REQ-008 bin_shift  input  4  bin width = 2^bin_shift cycles.
REQ-009 rd_en  input  1  host read strobe.
REQ-010 rd_addr  input  8  host bin index.
REQ-011 rd_data  output  32  bin contents.
REQ-012 rd_valid  output  1  rd_data is valid this cycle.
REQ-013 event_count  output  32  events binned.
REQ-014 overflow_count  output  32  events beyond the last bin.
REQ-015 missed_count  output  32  edges lost while busy.
REQ-016 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-017 Event = rising edge of double_trig (high now, registered previous value low) with enable=1; the block SHALL sample delta_time in that same cycle (cycle n).
REQ-018 bin = delta_time >> bin_shift; if bin > 255, the block SHALL increment overflow_count at n+1, perform no RAM access, and stay in IDLE.
REQ-019 FSM states: CLEAR, IDLE, READ, WRITE.
- IDLE -> READ on an in-range event.
- READ -> WRITE.
- WRITE -> IDLE.
- Any state -> CLEAR on clear.
REQ-020 READ (n+1) SHALL issue a port-A read of the bin; WRITE (n+2) SHALL write data+1, saturating at 0xFFFFFFFF, and increment event_count; the FSM SHALL be in IDLE at n+3.
REQ-021 An event detected while the FSM is not IDLE SHALL increment missed_count only.
REQ-022 CLEAR SHALL zero all three counters on entry, then write 0 to bins 0..255 over 256 consecutive cycles before returning to IDLE.
REQ-023 clear arriving in the same cycle as an event SHALL win; that event SHALL count as missed after the counters are zeroed.
REQ-024 clear asserted during CLEAR SHALL restart the sweep at bin 0.
REQ-025 Any mid-operation clear in READ/WRITE SHALL abort the pending increment.
REQ-026 Host reads SHALL use independent port B with 1-cycle latency: rd_en at cycle k gives rd_valid=1 and rd_data=mem[rd_addr] at k+1; rd_valid SHALL be 0 otherwise.
REQ-027 Reads SHALL be accepted in every state; a same-cycle read of the bin being written SHALL return the old value.
REQ-028 All counters SHALL saturate at 0xFFFFFFFF.
REQ-029 double_trig held high SHALL produce exactly one event.

Reset
REQ-030 On rst, the block SHALL reset:
- state to CLEAR at bin 0;
- counters, rd_data, rd_valid and the edge register to 0;
- busy to 1.
REQ-031 After rst deassertion, the block SHALL complete the 256-cycle sweep before accepting events; RAM contents are not otherwise reset.

Structure
REQ-032 Package decay_hist_pkg SHALL hold NUM_BINS=256, BIN_W=8, CNT_W=32, DELTA_W=16 and the FSM state enum.
REQ-033 Memory SHALL be one sub-module, hist_dpram: 256x32, port A read/write, port B read-only, registered reads, old-data read-during-write.

Verification
REQ-034 Scenario: release rst, hold double_trig=0 -> busy=1 for 256 cycles then 0; reading bins 0, 128 and 255 returns 0.
REQ-035 Scenario: bin_shift=0, edge with delta_time=37 -> bin 37 reads 1, event_count=1, busy high exactly 3 cycles.
REQ-036 Scenario: bin_shift=2, delta_time=1023 -> bin 255 incremented; delta_time=1024 -> overflow_count=1 and no bin changed.
REQ-037 Scenario: second edge 2 cycles after the first -> missed_count=1, event_count=1.
REQ-038 Scenario: clear coincident with an edge -> all bins 0, event_count=0, missed_count=1 after the sweep.
REQ-039 Scenario: double_trig held high 50 cycles with enable=1, then an edge with enable=0 -> exactly one event counted, counters otherwise unchanged.

Source files
------------

// File: rtl/decay_hist_pkg.sv
// Shared sizes, FSM state encoding and the saturating increment for the
// decay-time histogram.
package decay_hist_pkg;

    localparam int NUM_BINS = 256;
    localparam int BIN_W    = 8;
    localparam int CNT_W    = 32;
    localparam int DELTA_W  = 16;

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hist_dpram.sv
// 256x32 histogram store: port A read/write for the FSM, port B read-only for
// the host. Both reads are registered and return old data on a same-address write.
module hist_dpram
    import decay_hist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we_a,
    input  logic             i_re_a,
    input  logic [BIN_W-1:0] i_addr_a,
    input  logic [CNT_W-1:0] i_wdata_a,
    output logic [CNT_W-1:0] o_q_a,
    input  logic             i_re_b,
    input  logic [BIN_W-1:0] i_addr_b,
    output logic [CNT_W-1:0] o_q_b
);

    logic [CNT_W-1:0] r_mem [NUM_BINS];
    logic [CNT_W-1:0] r_q_a;
    logic [CNT_W-1:0] r_q_b;

    // Array itself is not reset; the controller sweeps it to zero instead.
    always_ff @(posedge clk) begin
        if (i_we_a) begin
            r_mem[i_addr_a] <= i_wdata_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_a <= '0;
            r_q_b <= '0;
        end else begin
            if (i_re_a) begin
                r_q_a <= r_mem[i_addr_a];
            end
            if (i_re_b) begin
                r_q_b <= r_mem[i_addr_b];
            end
        end
    end

    assign o_q_a = r_q_a;
    assign o_q_b = r_q_b;

endmodule

// File: rtl/decay_time_histogram.sv
// Bins double-pulse decay intervals into a 256-entry histogram with a host read port.
//   state    | meaning
//   CLEAR    | zeroing bins 0..255, one per cycle
//   IDLE     | waiting for a double_trig rising edge
//   READ     | port-A read of the target bin
//   WRITE    | write back bin+1 and count the event
module decay_time_histogram
    import decay_hist_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               double_trig,
    input  logic [DELTA_W-1:0] delta_time,
    input  logic               enable,
    input  logic               clear,
    input  logic [3:0]         bin_shift,
    input  logic               rd_en,
    input  logic [BIN_W-1:0]   rd_addr,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   event_count,
    output logic [CNT_W-1:0]   overflow_count,
    output logic [CNT_W-1:0]   missed_count,
    output logic               busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_trig_prev;
    logic [BIN_W-1:0]   r_bin;
    logic [BIN_W-1:0]   r_clr_addr;
    logic [CNT_W-1:0]   r_event_cnt;
    logic [CNT_W-1:0]   r_ovf_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;
    logic               r_rd_valid;

    logic               w_edge;
    logic               w_overflow;
    logic               w_accept;
    logic [DELTA_W-1:0] w_bin_full;
    logic               w_we_a;
    logic               w_re_a;
    logic [BIN_W-1:0]   w_addr_a;
    logic [CNT_W-1:0]   w_wdata_a;
    logic [CNT_W-1:0]   w_q_a;

    assign w_edge     = enable & double_trig & ~r_trig_prev;
    assign w_bin_full = delta_time >> bin_shift;
    assign w_overflow = |w_bin_full[DELTA_W-1:BIN_W];
    assign w_accept   = w_edge & ~clear & (r_state == ST_IDLE) & ~w_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we_a      = 1'b0;
        w_re_a      = 1'b0;
        w_addr_a    = r_bin;
        w_wdata_a   = '0;
        unique case (r_state)
            ST_CLEAR: begin
                w_we_a   = 1'b1;
                w_addr_a = r_clr_addr;
                if (r_clr_addr == LAST_BIN) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_re_a      = 1'b1;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                // A clear landing here drops the increment entirely.
                w_we_a      = ~clear;
                w_wdata_a   = sat_inc(w_q_a);
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
        if (clear) begin
            w_state_nxt = ST_CLEAR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_prev <= 1'b0;
            r_bin       <= '0;
            r_clr_addr  <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_trig_prev <= double_trig;
            r_rd_valid  <= rd_en;
            if (w_accept) begin
                r_bin <= w_bin_full[BIN_W-1:0];
            end
            if (clear) begin
                r_clr_addr <= '0;
            end else if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + BIN_W'(1);
            end
        end
    end

    // Clear wins over a coincident edge, which then lands as the first miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_event_cnt <= '0;
            r_ovf_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else if (clear) begin
            r_event_cnt <= '0;
            r_ovf_cnt   <= '0;
            r_miss_cnt  <= {{(CNT_W-1){1'b0}}, w_edge};
        end else begin
            if (w_edge) begin
                if (r_state != ST_IDLE) begin
                    r_miss_cnt <= sat_inc(r_miss_cnt);
                end else if (w_overflow) begin
                    r_ovf_cnt <= sat_inc(r_ovf_cnt);
                end
            end
            if (r_state == ST_WRITE) begin
                r_event_cnt <= sat_inc(r_event_cnt);
            end
        end
    end

    hist_dpram u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_we_a    (w_we_a),
        .i_re_a    (w_re_a),
        .i_addr_a  (w_addr_a),
        .i_wdata_a (w_wdata_a),
        .o_q_a     (w_q_a),
        .i_re_b    (rd_en),
        .i_addr_b  (rd_addr),
        .o_q_b     (rd_data)
    );

    assign rd_valid       = r_rd_valid;
    assign event_count    = r_event_cnt;
    assign overflow_count = r_ovf_cnt;
    assign missed_count   = r_miss_cnt;
    // Busy also covers the cycle in which an event is taken.
    assign busy           = (r_state != ST_IDLE) | w_accept;

endmodule

// File: tb/tb_decay_time_histogram.sv
// Directed bench for decay_time_histogram: sweep, binning, overflow, misses,
// clear handling and host reads, against hand-computed expectations.
module tb_decay_time_histogram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        double_trig = 1'b0;
    logic [15:0] delta_time = '0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  bin_shift = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [31:0] rd_data, event_count, overflow_count, missed_count;
    logic        rd_valid, busy;

    int vectors = 0;
    int miscompares = 0;

    decay_time_histogram dut (
        .clk            (clk),
        .rst            (rst),
        .double_trig    (double_trig),
        .delta_time     (delta_time),
        .enable         (enable),
        .clear          (clear),
        .bin_shift      (bin_shift),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .event_count    (event_count),
        .overflow_count (overflow_count),
        .missed_count   (missed_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [31:0] d, output logic v);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        d     = rd_data;
        v     = rd_valid;
        rd_en = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 600) begin
            n++;
            step();
        end
    endtask

    task automatic pulse_event(input logic [15:0] d);
        double_trig = 1'b1;
        delta_time  = d;
        step();
        double_trig = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic v;
        int n;
        repeat (3) step();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
        vectors++; if (event_count !== 32'd0) begin miscompares++; $display("FAIL reset_event_count: got %0d want 0", event_count); end
        vectors++; if (overflow_count !== 32'd0) begin miscompares++; $display("FAIL reset_overflow: got %0d want 0", overflow_count); end
        vectors++; if (missed_count !== 32'd0) begin miscompares++; $display("FAIL reset_missed: got %0d want 0", missed_count); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        vectors++; if (rd_data !== 32'd0) begin miscompares++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        rst = 1'b0;
        wait_idle(n);
        vectors++; if (n !== 256) begin miscompares++; $display("FAIL reset_sweep_len: got %0d want 256", n); end
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] a;
            a = (i == 0) ? 8'd0 : (i == 1) ? 8'd128 : 8'd255;
            host_read(a, d, v);
            vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL sweep_rd_valid bin %0d: got %b want 1", a, v); end
            vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL sweep_bin %0d: got %0d want 0", a, d); end
        end
        step();
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_valid_idle: got %b want 0", rd_valid); end
    endtask

    task automatic test_single_event();
        logic [31:0] d;
        logic v;
        int n;
        bin_shift   = 4'd0;
        delta_time  = 16'd37;
        double_trig = 1'b1;
        #1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) n++;
            step();
        end
        double_trig = 1'b0;
        step();
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL event_busy_cycles: got %0d want 3", n); end
        vectors++; if (event_count !== 32'd1) begin miscompares++; $display("FAIL event_count_1: got %0d want 1", event_count); end
        host_read(8'd37, d, v);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL bin37: got %0d want 1", d); end
        host_read(8'd36, d, v);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL bin36: got %0d want 0", d); end
        host_read(8'd38, d, v);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL bin38: got %0d want 0", d); end
    endtask

    task automatic test_shift_boundary();
        logic [31:0] d;
        logic v;
        bin_shift = 4'd2;
        pulse_event(16'd1023);
        vectors++; if (event_count !== 32'd2) begin miscompares++; $display("FAIL event_count_2: got %0d want 2", event_count); end
        host_read(8'd255, d, v);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL bin255: got %0d want 1", d); end
        double_trig = 1'b1;
        delta_time  = 16'd1024;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL overflow_busy: got %b want 0", busy); end
        step();
        vectors++; if (overflow_count !== 32'd1) begin miscompares++; $display("FAIL overflow_count: got %0d want 1", overflow_count); end
        double_trig = 1'b0;
        repeat (3) step();
        vectors++; if (event_count !== 32'd2) begin miscompares++; $display("FAIL overflow_event_count: got %0d want 2", event_count); end
        host_read(8'd0, d, v);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL overflow_bin0: got %0d want 0", d); end
        host_read(8'd255, d, v);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL overflow_bin255: got %0d want 1", d); end
        bin_shift = 4'd15;
        pulse_event(16'hFFFF);
        host_read(8'd1, d, v);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL shift15_bin1: got %0d want 1", d); end
        vectors++; if (event_count !== 32'd3) begin miscompares++; $display("FAIL event_count_3: got %0d want 3", event_count); end
        bin_shift = 4'd0;
    endtask

    task automatic test_missed();
        logic [31:0] d;
        logic v;
        double_trig = 1'b1;
        delta_time  = 16'd10;
        step();
        double_trig = 1'b0;
        step();
        double_trig = 1'b1;
        delta_time  = 16'd20;
        step();
        double_trig = 1'b0;
        repeat (3) step();
        vectors++; if (missed_count !== 32'd1) begin miscompares++; $display("FAIL missed_count: got %0d want 1", missed_count); end
        vectors++; if (event_count !== 32'd4) begin miscompares++; $display("FAIL missed_event_count: got %0d want 4", event_count); end
        host_read(8'd10, d, v);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL missed_bin10: got %0d want 1", d); end
        host_read(8'd20, d, v);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL missed_bin20: got %0d want 0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic v;
        double_trig = 1'b1;
        delta_time  = 16'd10;
        step();
        double_trig = 1'b0;
        step();
        step();
        double_trig = 1'b1;
        step();
        double_trig = 1'b0;
        repeat (3) step();
        vectors++; if (event_count !== 32'd6) begin miscompares++; $display("FAIL b2b_event_count: got %0d want 6", event_count); end
        vectors++; if (missed_count !== 32'd1) begin miscompares++; $display("FAIL b2b_missed: got %0d want 1", missed_count); end
        host_read(8'd10, d, v);
        vectors++; if (d !== 32'd3) begin miscompares++; $display("FAIL b2b_bin10: got %0d want 3", d); end
    endtask

    task automatic test_read_during_write();
        logic [31:0] d;
        logic v;
        double_trig = 1'b1;
        delta_time  = 16'd37;
        step();
        double_trig = 1'b0;
        step();
        host_read(8'd37, d, v);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL rdw_old_data: got %0d want 1", d); end
        vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL rdw_valid: got %b want 1", v); end
        step();
        host_read(8'd37, d, v);
        vectors++; if (d !== 32'd2) begin miscompares++; $display("FAIL rdw_new_data: got %0d want 2", d); end
        vectors++; if (event_count !== 32'd7) begin miscompares++; $display("FAIL rdw_event_count: got %0d want 7", event_count); end
    endtask

    task automatic test_hold_enable();
        logic [31:0] d;
        logic v;
        delta_time  = 16'd5;
        double_trig = 1'b1;
        repeat (50) step();
        double_trig = 1'b0;
        step();
        enable      = 1'b0;
        delta_time  = 16'd6;
        double_trig = 1'b1;
        repeat (5) step();
        double_trig = 1'b0;
        enable      = 1'b1;
        step();
        vectors++; if (event_count !== 32'd8) begin miscompares++; $display("FAIL hold_event_count: got %0d want 8", event_count); end
        vectors++; if (missed_count !== 32'd1) begin miscompares++; $display("FAIL hold_missed: got %0d want 1", missed_count); end
        vectors++; if (overflow_count !== 32'd1) begin miscompares++; $display("FAIL hold_overflow: got %0d want 1", overflow_count); end
        host_read(8'd5, d, v);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL hold_bin5: got %0d want 1", d); end
        host_read(8'd6, d, v);
        vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL hold_bin6: got %0d want 0", d); end
    endtask

    task automatic test_clear_coincident();
        logic [31:0] d;
        logic v;
        int n;
        clear       = 1'b1;
        double_trig = 1'b1;
        delta_time  = 16'd12;
        step();
        clear       = 1'b0;
        double_trig = 1'b0;
        vectors++; if (event_count !== 32'd0) begin miscompares++; $display("FAIL clr_event_count: got %0d want 0", event_count); end
        vectors++; if (missed_count !== 32'd1) begin miscompares++; $display("FAIL clr_missed: got %0d want 1", missed_count); end
        vectors++; if (overflow_count !== 32'd0) begin miscompares++; $display("FAIL clr_overflow: got %0d want 0", overflow_count); end
        wait_idle(n);
        vectors++; if (n !== 256) begin miscompares++; $display("FAIL clr_sweep_len: got %0d want 256", n); end
        for (int i = 0; i < 5; i++) begin
            logic [7:0] a;
            a = (i == 0) ? 8'd5 : (i == 1) ? 8'd10 : (i == 2) ? 8'd37 : (i == 3) ? 8'd255 : 8'd1;
            host_read(a, d, v);
            vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL clr_bin %0d: got %0d want 0", a, d); end
        end
        vectors++; if (missed_count !== 32'd1) begin miscompares++; $display("FAIL clr_missed_after: got %0d want 1", missed_count); end
    endtask

    task automatic test_clear_restart();
        logic [31:0] d;
        logic v;
        int n;
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (100) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        wait_idle(n);
        vectors++; if (n !== 256) begin miscompares++; $display("FAIL restart_sweep_len: got %0d want 256", n); end
        vectors++; if (missed_count !== 32'd0) begin miscompares++; $display("FAIL restart_missed: got %0d want 0", missed_count); end
        pulse_event(16'd3);
        vectors++; if (event_count !== 32'd1) begin miscompares++; $display("FAIL restart_event_count: got %0d want 1", event_count); end
        host_read(8'd3, d, v);
        vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL restart_bin3: got %0d want 1", d); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_shift_boundary();
        test_missed();
        test_back_to_back();
        test_read_during_write();
        test_hold_enable();
        test_clear_coincident();
        test_clear_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
